// File: rtl/aes_key_expand_128.sv
// ---------------------------------------------------------------------------
// aes_key_expand_128
// Iterative AES-128 key schedule. One schedule step per cycle, S-box built
// on the GF((2^4)^2) composite field. Round keys leave on a valid/ready
// stream, either 0..10 on the fly (REVERSE=0) or 10..0 after a full
// pre-expansion into an internal key store (REVERSE=1).
//
// Ports
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   start     start request, sampled only in IDLE
//   key_in    cipher key, byte 0 = bits [127:120], sampled on accepted start
//   busy      high from the cycle after accepted start through the done cycle
//   rk_valid  round key on rk_out is valid
//   rk_ready  consumer accepts rk_out when rk_valid && rk_ready
//   rk_out    round key
//   rk_idx    round number of rk_out (0..10)
//   done      pulse on the cycle the last round key is accepted
// ---------------------------------------------------------------------------
module aes_key_expand_128 #(
   parameter bit REVERSE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         done
);

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned N_KEYS = 11;
   localparam logic [IDX_W-1:0] LAST_RND  = IDX_W'(N_KEYS - 1);
   localparam logic [7:0]       RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_EMIT   = 2'd2
   } state_t;

   // ---------------- composite-field S-box ----------------
   // GF(2^2) multiply
   function automatic logic [1:0] mul_gf2(input logic [1:0] a, input logic [1:0] b);
      return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]),
              (a[1] & b[1]) ^ (a[0] & b[0])};
   endfunction

   // GF(2^2) multiply by phi = {10}
   function automatic logic [1:0] mul_phi(input logic [1:0] a);
      return {a[1] ^ a[0], a[1]};
   endfunction

   // GF(2^4) multiply over GF(2^2)
   function automatic logic [3:0] mul_nibble(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] hh;
      logic [1:0] ss;
      logic [1:0] ll;
      hh = mul_gf2(a[3:2], b[3:2]);
      ss = mul_gf2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
      ll = mul_gf2(a[1:0], b[1:0]);
      return {ss ^ ll, mul_phi(hh) ^ ll};
   endfunction

   function automatic logic [3:0] square_nibble(input logic [3:0] a);
      return {a[3], a[3] ^ a[2], a[2] ^ a[1], a[3] ^ a[1] ^ a[0]};
   endfunction

   // GF(2^4) multiply by lambda = {1100}
   function automatic logic [3:0] mul_lambda(input logic [3:0] a);
      return {a[2] ^ a[0], a[3] ^ a[2] ^ a[1] ^ a[0], a[3], a[2]};
   endfunction

   function automatic logic [3:0] invert_nibble(input logic [3:0] a);
      logic [3:0] q;
      q[3] = a[3] ^ (a[3] & a[2] & a[1]) ^ (a[3] & a[0]) ^ a[2];
      q[2] = (a[3] & a[2] & a[1]) ^ (a[3] & a[2] & a[0]) ^ (a[3] & a[0]) ^ a[2]
           ^ (a[2] & a[1]);
      q[1] = a[3] ^ (a[3] & a[2] & a[1]) ^ (a[3] & a[1] & a[0]) ^ a[2]
           ^ (a[2] & a[0]) ^ a[1];
      q[0] = (a[3] & a[2] & a[1]) ^ (a[3] & a[2] & a[0]) ^ (a[3] & a[1])
           ^ (a[3] & a[1] & a[0]) ^ (a[3] & a[0]) ^ a[2] ^ (a[2] & a[1])
           ^ (a[2] & a[1] & a[0]) ^ a[1] ^ a[0];
      return q;
   endfunction

   // GF(2^8) polynomial basis -> composite basis
   function automatic logic [7:0] isomorph(input logic [7:0] a);
      return {a[7] ^ a[5],
              a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[7] ^ a[5] ^ a[3] ^ a[2],
              a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1],
              a[7] ^ a[6] ^ a[2] ^ a[1],
              a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[6] ^ a[4] ^ a[1],
              a[6] ^ a[1] ^ a[0]};
   endfunction

   // composite basis -> GF(2^8) polynomial basis
   function automatic logic [7:0] inv_isomorph(input logic [7:0] a);
      return {a[7] ^ a[6] ^ a[5] ^ a[1],
              a[6] ^ a[2],
              a[6] ^ a[5] ^ a[1],
              a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[1],
              a[5] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[5] ^ a[4],
              a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[0]};
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] t;
      logic [3:0] s;
      logic [3:0] d;
      logic [3:0] di;
      t  = isomorph(x);
      s  = t[7:4] ^ t[3:0];
      d  = mul_lambda(square_nibble(t[7:4])) ^ mul_nibble(s, t[3:0]);
      di = invert_nibble(d);
      return affine(inv_isomorph({mul_nibble(t[7:4], di), mul_nibble(s, di)}));
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // ---------------- registers ----------------
   state_t             r_state;
   logic               r_busy;
   logic               r_valid;
   logic [KEY_W-1:0]   r_out;
   logic [IDX_W-1:0]   r_idx;
   logic [7:0]         r_rcon;
   logic [KEY_W-1:0]   r_work;
   logic [IDX_W-1:0]   r_cnt;
   logic [KEY_W-1:0]   r_store [N_KEYS];

   state_t             w_state_nxt;
   logic               w_busy_nxt;
   logic               w_valid_nxt;
   logic [KEY_W-1:0]   w_out_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [7:0]         w_rcon_nxt;
   logic [KEY_W-1:0]   w_work_nxt;
   logic [IDX_W-1:0]   w_cnt_nxt;
   logic               w_store_we;
   logic [IDX_W-1:0]   w_store_sel;
   logic [KEY_W-1:0]   w_store_data;

   // ---------------- schedule step ----------------
   logic [KEY_W-1:0]   w_step_in;
   logic [31:0]        w_rot;
   logic [31:0]        w_t;
   logic [31:0]        w_n0, w_n1, w_n2, w_n3;
   logic [KEY_W-1:0]   w_step;
   logic               w_hs;
   logic               w_last;

   // pre-expansion walks r_work; on-the-fly emission steps from the key on display
   assign w_step_in = (r_state == ST_EXPAND) ? r_work : r_out;
   assign w_rot     = {w_step_in[23:0], w_step_in[31:24]};
   assign w_t       = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                       sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {r_rcon, 24'h0};
   assign w_n0      = w_step_in[127:96] ^ w_t;
   assign w_n1      = w_step_in[95:64]  ^ w_n0;
   assign w_n2      = w_step_in[63:32]  ^ w_n1;
   assign w_n3      = w_step_in[31:0]   ^ w_n2;
   assign w_step    = {w_n0, w_n1, w_n2, w_n3};

   assign w_hs      = r_valid & rk_ready;
   assign w_last    = REVERSE ? (r_idx == '0) : (r_idx == LAST_RND);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_out   <= '0;
         r_idx   <= '0;
         r_rcon  <= RCON_INIT;
         r_work  <= '0;
         r_cnt   <= '0;
         for (int unsigned i = 0; i < N_KEYS; i++) begin
            r_store[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_valid <= w_valid_nxt;
         r_out   <= w_out_nxt;
         r_idx   <= w_idx_nxt;
         r_rcon  <= w_rcon_nxt;
         r_work  <= w_work_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_store_we) begin
            r_store[w_store_sel] <= w_store_data;
         end
      end
   end

   // ---------------- next-state / outputs ----------------
   always_comb begin
      w_state_nxt  = r_state;
      w_busy_nxt   = r_busy;
      w_valid_nxt  = r_valid;
      w_out_nxt    = r_out;
      w_idx_nxt    = r_idx;
      w_rcon_nxt   = r_rcon;
      w_work_nxt   = r_work;
      w_cnt_nxt    = r_cnt;
      w_store_we   = 1'b0;
      w_store_sel  = '0;
      w_store_data = '0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_busy_nxt = 1'b1;
               w_rcon_nxt = RCON_INIT;
               if (REVERSE) begin
                  w_state_nxt  = ST_EXPAND;
                  w_work_nxt   = key_in;
                  w_cnt_nxt    = IDX_W'(1);
                  w_store_we   = 1'b1;
                  w_store_sel  = '0;
                  w_store_data = key_in;
               end else begin
                  w_state_nxt = ST_EMIT;
                  w_out_nxt   = key_in;
                  w_idx_nxt   = '0;
                  w_valid_nxt = 1'b1;
               end
            end
         end

         ST_EXPAND: begin
            w_work_nxt   = w_step;
            w_cnt_nxt    = r_cnt + IDX_W'(1);
            w_rcon_nxt   = xtime(r_rcon);
            w_store_we   = 1'b1;
            w_store_sel  = r_cnt;
            w_store_data = w_step;
            // round 10 goes straight to the output as it is computed
            if (r_cnt == LAST_RND) begin
               w_state_nxt = ST_EMIT;
               w_out_nxt   = w_step;
               w_idx_nxt   = LAST_RND;
               w_valid_nxt = 1'b1;
               w_rcon_nxt  = RCON_INIT;
            end
         end

         ST_EMIT: begin
            if (w_hs) begin
               if (w_last) begin
                  w_state_nxt = ST_IDLE;
                  w_valid_nxt = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_rcon_nxt  = RCON_INIT;
               end else if (REVERSE) begin
                  w_out_nxt = r_store[r_idx - IDX_W'(1)];
                  w_idx_nxt = r_idx - IDX_W'(1);
               end else begin
                  w_out_nxt  = w_step;
                  w_idx_nxt  = r_idx + IDX_W'(1);
                  w_rcon_nxt = xtime(r_rcon);
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy     = r_busy;
   assign rk_valid = r_valid;
   assign rk_out   = r_out;
   assign rk_idx   = r_idx;
   // must coincide with the final handshake, so it is decoded from the live ready
   assign done     = w_hs & w_last;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_128
// Drives a forward (REVERSE=0) and a reverse (REVERSE=1) instance side by
// side and checks every cycle against a word-level FIPS-197 key expansion
// model with a field-arithmetic S-box table.
// ---------------------------------------------------------------------------
module tb_aes_key_expand_128;

   logic         clk;
   logic         rst;
   logic [1:0]   start;
   logic [1:0]   rk_ready;
   logic [1:0]   busy;
   logic [1:0]   rk_valid;
   logic [1:0]   done;
   logic [127:0] key_in [2];
   logic [127:0] rk_out [2];
   logic [3:0]   rk_idx [2];

   aes_key_expand_128 #(.REVERSE(1'b0)) u_fwd (
      .clk(clk), .rst(rst), .start(start[0]), .key_in(key_in[0]),
      .busy(busy[0]), .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]),
      .rk_out(rk_out[0]), .rk_idx(rk_idx[0]), .done(done[0]));

   aes_key_expand_128 #(.REVERSE(1'b1)) u_rev (
      .clk(clk), .rst(rst), .start(start[1]), .key_in(key_in[1]),
      .busy(busy[1]), .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]),
      .rk_out(rk_out[1]), .rk_idx(rk_idx[1]), .done(done[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   int           n_checks;
   int           n_fail;
   logic [7:0]   sbox_t [256];
   bit           m_busy [2];
   int           m_wait [2];
   int           m_pos  [2];
   logic [127:0] m_key  [2];
   logic [127:0] cap    [2][11];

   task automatic chk(input string name, input int g, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (dut%0d): got %h, expected %h", name, g, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse by search, then affine map
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int k = 1; k < 256; k++) begin
            if (gmul(8'(v), 8'(k)) == 8'h01) inv = 8'(k);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
         end
         sbox_t[v] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   // textbook 44-word expansion, returns round key r
   function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i - 4] ^ t;
      end
      return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endfunction

   // per-cycle compare against the model, then advance the model to the next edge
   task automatic model_step();
      bit   ev;
      int   ei;
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            chk("rst_busy",  g, 128'(busy[g]),     '0);
            chk("rst_valid", g, 128'(rk_valid[g]), '0);
            chk("rst_done",  g, 128'(done[g]),     '0);
            chk("rst_out",   g, rk_out[g],         '0);
            chk("rst_idx",   g, 128'(rk_idx[g]),   '0);
            m_busy[g] = 1'b0;
            m_wait[g] = 0;
            m_pos[g]  = 0;
            for (int i = 0; i < 11; i++) cap[g][i] = '0;
         end else begin
            ev = m_busy[g] && (m_wait[g] == 0);
            ei = (g == 1) ? 10 - m_pos[g] : m_pos[g];
            chk("busy",  g, 128'(busy[g]),     128'(m_busy[g]));
            chk("valid", g, 128'(rk_valid[g]), 128'(ev));
            chk("done",  g, 128'(done[g]),     128'(ev && rk_ready[g] && m_pos[g] == 10));
            if (ev) begin
               chk("rk_idx", g, 128'(rk_idx[g]), 128'(ei));
               chk("rk_out", g, rk_out[g], round_key(m_key[g], ei));
               cap[g][ei] = rk_out[g];
            end
            if (!m_busy[g]) begin
               if (start[g]) begin
                  m_busy[g] = 1'b1;
                  m_key[g]  = key_in[g];
                  m_pos[g]  = 0;
                  m_wait[g] = (g == 1) ? 10 : 0;
               end
            end else if (m_wait[g] > 0) begin
               m_wait[g]--;
            end else if (rk_ready[g]) begin
               m_pos[g]++;
               if (m_pos[g] == 11) m_busy[g] = 1'b0;
            end
         end
      end
   endtask

   // called at posedge+1; returns at the next posedge+1
   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      start = 2'b00;
      for (int i = 0; i < budget && busy != 2'b00; i++) cycle();
      chk("drain_timeout", 0, 128'(busy), '0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 2'b00;
      rk_ready = 2'b00;
      key_in[0] = '0;
      key_in[1] = '0;
      for (int g = 0; g < 2; g++) begin
         m_busy[g] = 1'b0; m_wait[g] = 0; m_pos[g] = 0; m_key[g] = '0;
      end

      build_sbox();
      chk("model_fips_r1",  0, round_key(FIPS_KEY, 1),  FIPS_R1);
      chk("model_fips_r10", 0, round_key(FIPS_KEY, 10), FIPS_R10);
      chk("model_zero_r1",  0, round_key('0, 1),        ZERO_R1);
      chk("model_seq_r10",  0, round_key(SEQ_KEY, 10),  SEQ_R10);

      @(posedge clk);
      #1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // FIPS key, full throughput, both orders
      rk_ready  = 2'b11;
      key_in[0] = FIPS_KEY;
      key_in[1] = FIPS_KEY;
      start     = 2'b11;
      cycle();
      start     = 2'b00;
      wait_idle(40);
      chk("fwd_idx0",  0, cap[0][0],  FIPS_KEY);
      chk("fwd_idx1",  0, cap[0][1],  FIPS_R1);
      chk("fwd_idx10", 0, cap[0][10], FIPS_R10);
      chk("rev_idx10", 1, cap[1][10], FIPS_R10);
      chk("rev_idx0",  1, cap[1][0],  FIPS_KEY);

      // randomized keys, backpressure and stray starts
      for (int i = 0; i < 600; i++) begin
         rk_ready  = 2'($urandom_range(0, 3));
         start     = {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)};
         key_in[0] = {$urandom, $urandom, $urandom, $urandom};
         key_in[1] = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end
      start    = 2'b00;
      rk_ready = 2'b11;
      wait_idle(60);

      // starts mid-run and on the done cycle are ignored; one cycle later is taken
      key_in[0] = FIPS_KEY;
      start     = 2'b01;
      cycle();
      start     = 2'b00;
      for (int i = 0; i < 20 && !(rk_valid[0] && rk_idx[0] == 4'd4); i++) cycle();
      chk("reach_idx4", 0, 128'(rk_idx[0]), 128'(4));
      key_in[0] = {$urandom, $urandom, $urandom, $urandom};
      start     = 2'b01;
      cycle();
      start     = 2'b00;
      for (int i = 0; i < 20 && !done[0]; i++) cycle();
      chk("reach_done", 0, 128'(done[0]), 128'(1));
      key_in[0] = {$urandom, $urandom, $urandom, $urandom};
      start     = 2'b01;
      cycle();
      key_in[0] = '0;
      cycle();
      start     = 2'b00;
      chk("ignored_start_idx10", 0, cap[0][10], FIPS_R10);
      chk("restart_busy", 0, 128'(busy[0]), 128'(1));
      wait_idle(40);
      chk("restart_zero_idx1", 0, cap[0][1], ZERO_R1);

      // reset in the middle of a run, then a clean run
      key_in[0] = SEQ_KEY;
      key_in[1] = SEQ_KEY;
      start     = 2'b11;
      cycle();
      start     = 2'b00;
      for (int i = 0; i < 20 && !(rk_valid[0] && rk_idx[0] == 4'd6); i++) cycle();
      chk("reach_idx6", 0, 128'(rk_idx[0]), 128'(6));
      rst = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("async_rst_busy",  g, 128'(busy[g]),     '0);
         chk("async_rst_valid", g, 128'(rk_valid[g]), '0);
         chk("async_rst_out",   g, rk_out[g],         '0);
         chk("async_rst_idx",   g, 128'(rk_idx[g]),   '0);
      end
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      cycle();
      start = 2'b11;
      cycle();
      start = 2'b00;
      wait_idle(40);
      chk("seq_fwd_idx10", 0, cap[0][10], SEQ_R10);
      chk("seq_rev_idx10", 1, cap[1][10], SEQ_R10);
      chk("seq_rev_idx0",  1, cap[1][0],  SEQ_KEY);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_key_expand_128.md
Name: aes_key_expand_128

Overview:
Iterative AES-128 key schedule. Accepts a 128-bit cipher key and produces the 11 round keys (round 0..10) one per handshake on a valid/ready output stream. It feeds the round datapath (AESENC/AESDEC rounds) with round keys. Its SubWord step uses the package composite-field S-box: isomorph, GF(2^4) inversion via square_nibble/mul_lambda/invert_nibble/mul_gf2, inv_isomorph, then affine. Encryption order (0->10) is produced on the fly; decryption order (10->0) is produced after a full pre-expansion into an internal key store.

Parameters:
REVERSE, 0, 0 = emit round keys 0..10 on the fly; 1 = expand all 11 keys into the internal store first, then emit 10..0.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  start request; sampled only in IDLE
key_in  in  128 (aes_128)  cipher key, byte 0 = bits [127:120]; sampled on accepted start
busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
rk_valid  out  1  round key on rk_out is valid
rk_ready  in  1  consumer accepts rk_out when rk_valid && rk_ready
rk_out  out  128 (aes_128)  round key
rk_idx  out  4  round number of rk_out (0..10)
done  out  1  one-cycle pulse on the cycle the last key is accepted

Behaviour:
- Reset (async assert, released synchronously to clk): state=IDLE; busy=0, rk_valid=0, done=0, rk_out=0, rk_idx=0, rcon=8'h01, key store cleared. Reset mid-operation aborts immediately; no partial output survives.
- States: IDLE, EXPAND (REVERSE=1 only), EMIT.
- Schedule step (combinational from current key K = w0..w3, rcon): t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; RotWord takes bytes 13,14,15,12; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2. Next rcon = xtime(rcon), sequence 01,02,04,08,10,20,40,80,1B,36.
- REVERSE=0: IDLE + start -> EMIT; next cycle rk_out=key_in, rk_idx=0, rk_valid=1, busy=1. In EMIT, on a handshake with rk_idx<10: rk_out<=next key, rk_idx++, rcon<=xtime(rcon); rk_valid stays 1, giving zero-bubble back-to-back throughput. On a handshake with rk_idx==10: done=1 that cycle; next cycle state=IDLE, rk_valid=0, busy=0, rcon=01.
- REVERSE=1: IDLE + start -> EXPAND; store[0]=key_in. Each EXPAND cycle computes one key into store[i], i=1..10, taking 10 cycles with rk_valid=0. Then -> EMIT with rk_out=store[10], rk_idx=10. Each handshake decrements the index. The handshake at rk_idx==0 pulses done and returns to IDLE.
- Backpressure: while rk_valid && !rk_ready, rk_out and rk_idx hold stable. rk_valid never drops without a handshake, except on reset.
- start while busy is ignored, and key_in is not resampled. start on the same cycle as the final handshake is ignored; a new start is accepted in IDLE at the earliest the cycle after done.
- Latency: start to first rk_valid is 1 cycle (REVERSE=0) or 11 cycles (REVERSE=1).
- S-box path: combinational, single cycle. No pipelining inside the step.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, REVERSE=0, rk_ready=1 -> 11 consecutive beats. idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done pulses with the idx10 beat; busy falls the next cycle.
- Same key, REVERSE=1 -> rk_valid first rises 11 cycles after start. Beat order is idx10 (d014f9a8...), idx9, ..., idx0 (2b7e1516...). done pulses with idx0.
- Random rk_ready (about 50% duty) -> rk_out/rk_idx stay stable while stalled. The beat sequence is identical to the rk_ready=1 run. No beat is duplicated or dropped.
- Pulse start at idx 4, and again on the done cycle -> both ignored, sequence completes unchanged. A start one cycle after done begins a new run with rcon reset (idx1 matches the scheduled value).
- Assert rst during beat idx 6, then release -> all outputs 0 immediately. A new start with key 000102030405060708090a0b0c0d0e0f gives idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- All-zero key -> idx1 = 62636363626363636263636362636363, which exercises S-box(00)=63 and rcon=01.
